mips_mc_ctrl: RTL
=================

# mips_mc_ctrl

Multi-cycle main control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and write-back for the supported subset: R-type ADD/SUB/AND/OR/NOR/SLT/XOR, ADDI, LW, SW, BEQ, BNE and J. It drives every datapath mux, enable and ALU control code, including `pcEn`, which also qualifies instruction capture in the checker. It waits on a memory-ready handshake and reports retired instructions.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `inst  in  32`: instruction register contents; opcode `inst[31:26]`, funct `inst[5:0]`; opcode constants from `AluCtrlSig_pkg`.
- `zero  in  1`: ALU zero flag.
- `mem_ready  in  1`: memory completes the current read or write this cycle.
- `pcEn  out  1`: PC write enable.
- `pc_src  out  2`: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump `{PC[31:28], inst[25:0], 2'b00}`.
- `ir_write  out  1`: instruction register load.
- `iord  out  1`: memory address select; 0 PC, 1 ALUOut.
- `mem_read`, `mem_write  out  1`: memory strobes.
- `reg_write`, `reg_dst`, `mem_to_reg  out  1`: register-file write controls; `reg_dst` 1 selects rd.
- `alu_src_a  out  1`: 0 PC, 1 rs.
- `alu_src_b  out  2`: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_ctrl  out  4`: ADD=2, SUB=6, AND=0, OR=1, NOR=12, SLT=7, XOR=13.
- `instr_done  out  1`: one-cycle pulse in the final cycle of each retired instruction.
- `instr_count  out  CNT_W`: count of retired instructions.
- `illegal  out  1`: sticky illegal-instruction flag.
- `state_dbg  out  4`: current state encoding.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, ALUWB=7, BRANCH=8, ADDIEXE=9, JUMP=10, TRAP=11.
- Outputs are decoded from the state only (Moore), except the `mem_ready`, `zero` and opcode qualifiers listed below. Any control output not listed for a state is 0.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD.
  - On `mem_ready`: `ir_write`=1, `pcEn`=1, `pc_src`=00, then go to DECODE. Otherwise stay.
- DECODE:
  - `alu_src_a`=0, `alu_src_b`=11, ADD (precomputes branch target).
  - Next state by opcode: LW/SW→MEMADR, R-type→RTEXE, ADDI→ADDIEXE, BEQ/BNE→BRANCH, J→JUMP, other→illegal handling.
  - An R-type with an unsupported funct is also illegal.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. LW→MEMRD, SW→MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1, then go to FETCH.
- MEMWR: `mem_write`=1, `iord`=1. On `mem_ready`: `instr_done`=1, then go to FETCH.
- RTEXE: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct (add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A). Then go to ALUWB.
- ADDIEXE: `alu_src_a`=1, `alu_src_b`=10, ADD. Then go to ALUWB.
- ALUWB: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=(opcode==R-type), `instr_done`=1, then go to FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01.
  - `pcEn`=`zero` for BEQ and `!zero` for BNE.
  - `instr_done`=1, then go to FETCH.
- JUMP: `pcEn`=1, `pc_src`=10, `instr_done`=1, then go to FETCH.
- `instr_count` increments on every edge where `instr_done`=1 and wraps from 2^CNT_W−1 to 0.
- `inst` must be stable outside FETCH; it only changes via `ir_write`.

## Timing
- Reset values (forced combinationally while `rst`=1, and on release):
  - state=FETCH.
  - Every control output 0, including `mem_read`, `mem_write` and `pcEn`.
  - `instr_done`=0, `instr_count`=0, `illegal`=0, `state_dbg`=0.
- Cycles per instruction with `mem_ready` held 1:
  - R-type/ADDI: 4. LW: 5. SW: 4. BEQ/BNE/J: 3.
  - Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle; there is no timeout.
- Reset mid-instruction aborts it:
  - A pending write is dropped; `mem_write` falls in the same cycle `rst` rises.
  - No `instr_done` is produced and no count is taken.
- `mem_ready` high in a state that does not access memory is ignored.

## Configuration
- `MIPS_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode or funct moves DECODE→TRAP.
  - TRAP drives all control outputs 0 and sets `illegal`=1, holding it until `rst`.
  - No `instr_done`.
- Not defined:
  - DECODE→FETCH directly, so the instruction executes as a 2-cycle NOP.
  - No `instr_done`, no count; `illegal` tied to 0 (port retained).

## Test plan
- Reset asserted during MEMWR with `mem_ready`=0 → `mem_write` drops the same cycle; after release state_dbg=0 and `instr_count`=0.
- `add` (funct 0x20) with `mem_ready`=1 → states 0,1,6,7; `alu_ctrl`=2 in RTEXE; `reg_dst`=1 and `reg_write`=1 in ALUWB; `instr_done` pulses once; count 0→1.
- LW with `mem_ready` low for 3 cycles in MEMRD → 8 total cycles; `mem_to_reg`=1 in MEMWB. SW → `mem_write`=1, `iord`=1 only in MEMWR.
- BEQ with `zero`=1 → `pcEn`=1, `pc_src`=01. BNE with `zero`=1 → `pcEn`=0. Both take 3 cycles.
- J → `pcEn`=1, `pc_src`=10 in JUMP. Preload `instr_count` to 2^CNT_W−1 (or use `CNT_W`=4 and run 16 instructions) → wraps to 0.
- Opcode 0x3F: with the macro, state_dbg=11 and `illegal`=1 held until reset; without the macro, back to FETCH after 2 cycles and `illegal`=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main control FSM for the MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional feature: define MIPS_ILLEGAL_TRAP_EN to park illegal instructions in TRAP with a sticky flag.

package AluCtrlSig_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_XOR = 4'd13;
endpackage

module mips_mc_ctrl
   import AluCtrlSig_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcEn,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic             illegal,
   output logic [3:0]       state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTEXE   = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEXE = 4'd9,
      S_JUMP    = 4'd10,
      S_TRAP    = 4'd11
   } state_t;

   state_t           state;
   state_t           state_nxt;
   state_t           illegal_target;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [CNT_W-1:0] cnt_q;
   logic             unused_inst_bits;

   assign opcode           = inst[31:26];
   assign funct            = inst[5:0];
   assign unused_inst_bits = ^inst[25:6];
   assign state_dbg        = state;
   assign instr_count      = cnt_q;

   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: funct_ok = 1'b1;
         default:                                               funct_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] funct_alu(input logic [5:0] f);
      case (f)
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_XOR:  funct_alu = ALU_XOR;
         FN_NOR:  funct_alu = ALU_NOR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_alu = ALU_ADD;
      endcase
   endfunction

`ifdef MIPS_ILLEGAL_TRAP_EN
   assign illegal_target = S_TRAP;
`else
   // Unsupported encodings fall straight back to fetch: a two-cycle NOP.
   assign illegal_target = S_FETCH;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:   state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:    state_nxt = S_MEMADR;
               OP_RTYPE:        state_nxt = funct_ok(funct) ? S_RTEXE : illegal_target;
               OP_ADDI:         state_nxt = S_ADDIEXE;
               OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
               OP_J:            state_nxt = S_JUMP;
               default:         state_nxt = illegal_target;
            endcase
         end
         S_MEMADR:  state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_nxt = S_FETCH;
         S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_RTEXE:   state_nxt = S_ALUWB;
         S_ADDIEXE: state_nxt = S_ALUWB;
         S_ALUWB:   state_nxt = S_FETCH;
         S_BRANCH:  state_nxt = S_FETCH;
         S_JUMP:    state_nxt = S_FETCH;
         S_TRAP:    state_nxt = S_TRAP;
         default:   state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Moore decode; reset forces every strobe low so an in-flight write dies immediately.
   always_comb begin
      pcEn       = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_AND;
      instr_done = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               alu_ctrl  = ALU_ADD;
               ir_write  = mem_ready;
               pcEn      = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               alu_ctrl  = ALU_ADD;
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_write  = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
            end
            S_RTEXE: begin
               alu_src_a = 1'b1;
               alu_ctrl  = funct_alu(funct);
            end
            S_ADDIEXE: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = ALU_ADD;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = (opcode == OP_RTYPE);
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_ctrl   = ALU_SUB;
               pc_src     = 2'b01;
               pcEn       = (opcode == OP_BNE) ? !zero : zero;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pcEn       = 1'b1;
               pc_src     = 2'b10;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (instr_done) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

`ifdef MIPS_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal <= 1'b0;
      end else if (state_nxt == S_TRAP) begin
         illegal <= 1'b1;
      end
   end
`else
   assign illegal = 1'b0;
`endif

endmodule
